// File: rtl/nanov_fetch_pkg.sv
// Shared definitions for the nanoV instruction fetch unit: widths, SPI constants,
// sequencer states and the serial-bit to shadow-bit mapping.
package nanov_fetch_pkg;

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned CYC_W   = 3;

    localparam logic [7:0]         SPI_READ_CMD    = 8'h03;
    localparam logic [INSTR_W-1:0] NOP_INSTR       = 32'h00000013;
    localparam logic [ADDR_W-1:0]  WORD_ALIGN_MASK = 24'hFFFFFC;

    localparam logic [CNT_W-1:0] CMD_LAST  = 5'd7;
    localparam logic [CNT_W-1:0] ADDR_LAST = 5'd23;
    localparam logic [CNT_W-1:0] DATA_LAST = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_PAUSE
    } fetch_state_e;

    // Serial bit k lands in byte k/8, MSB first within the byte (little-endian word).
    function automatic logic [CNT_W-1:0] shadow_idx(input logic [CNT_W-1:0] k);
        return {k[4:3], ~k[2:0]};
    endfunction

endpackage

// File: rtl/nanov_fetch_buffer.sv
// One-word shadow register filled a bit at a time from the flash, with a full flag.
// word_c presents the word including the bit being written this cycle.
module nanov_fetch_buffer
    import nanov_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [CNT_W-1:0]   wr_idx,
    input  logic               wr_bit,
    input  logic               take,
    output logic               full,
    output logic [INSTR_W-1:0] word_c
);

    logic [INSTR_W-1:0] shadow;
    logic               last_c;

    always_comb begin
        word_c = shadow;
        if (wr_en) begin
            word_c[shadow_idx(wr_idx)] = wr_bit;
        end
    end

    assign last_c = wr_en && (wr_idx == DATA_LAST);

    // A word completing on the same edge it is taken never shows as full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow <= '0;
            full   <= 1'b0;
        end else begin
            shadow <= word_c;
            if (clear || take) begin
                full <= 1'b0;
            end else if (last_c) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nanov_fetch.sv
// nanoV instruction fetch: streams words from SPI flash (read command 0x03) and
// presents them to a bit-serial core, one 32-clock pass per instruction cycle.
module nanov_fetch
    import nanov_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDR = 24'h000000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               spi_miso,
    output logic               spi_mosi,
    output logic               spi_cs_n,
    output logic               spi_clk_en,
    input  logic               branch,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               next_cycle,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [CNT_W-1:0]   counter,
    output logic [CYC_W-1:0]   cycle,
    output logic [ADDR_W-1:0]  pc
);

    fetch_state_e       state;
    fetch_state_e       state_nx;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_nx;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [ADDR_W-1:0]  fetch_addr_nx;
    logic               mosi_nx;

    logic               wrap_c;
    logic               redirect_c;
    logic               hold_c;
    logic               wr_en_c;
    logic               last_bit_c;
    logic               ready_c;
    logic               drain_c;
    logic               buf_full;
    logic [INSTR_W-1:0] buf_word_c;

    assign wrap_c     = instr_valid && (counter == DATA_LAST);
    assign redirect_c = wrap_c && branch;
    assign hold_c     = wrap_c && !branch && next_cycle;
    assign wr_en_c    = (state == ST_DATA);
    assign last_bit_c = wr_en_c && (bit_cnt == DATA_LAST);
    assign ready_c    = buf_full || last_bit_c;
    // While running, a word is consumed only at a pass end; when idle, as soon as it is full.
    assign drain_c    = instr_valid ? (wrap_c && !branch && !next_cycle && ready_c) : buf_full;

    nanov_fetch_buffer u_buffer (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (redirect_c),
        .wr_en  (wr_en_c),
        .wr_idx (bit_cnt),
        .wr_bit (spi_miso),
        .take   (drain_c),
        .full   (buf_full),
        .word_c (buf_word_c)
    );

    // Sequencer next state, bit index and fetch address.
    always_comb begin
        state_nx      = state;
        bit_nx        = bit_cnt;
        fetch_addr_nx = fetch_addr;
        case (state)
            ST_IDLE: begin
                state_nx = ST_CMD;
                bit_nx   = '0;
            end
            ST_CMD: begin
                if (bit_cnt == CMD_LAST) begin
                    state_nx = ST_ADDR;
                    bit_nx   = '0;
                end else begin
                    bit_nx = bit_cnt + CNT_W'(1);
                end
            end
            ST_ADDR: begin
                if (bit_cnt == ADDR_LAST) begin
                    state_nx = ST_DATA;
                    bit_nx   = '0;
                end else begin
                    bit_nx = bit_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                bit_nx = bit_cnt + CNT_W'(1);
                if (last_bit_c) begin
                    fetch_addr_nx = fetch_addr + ADDR_W'(4);
                    if (!drain_c) begin
                        state_nx = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (drain_c) begin
                    state_nx = ST_DATA;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                bit_nx   = '0;
            end
        endcase
        if (redirect_c) begin
            state_nx      = ST_IDLE;
            bit_nx        = '0;
            fetch_addr_nx = branch_addr & WORD_ALIGN_MASK;
        end
    end

    always_comb begin
        mosi_nx = 1'b0;
        if (state_nx == ST_CMD) begin
            mosi_nx = SPI_READ_CMD[3'd7 - bit_nx[2:0]];
        end else if (state_nx == ST_ADDR) begin
            mosi_nx = fetch_addr_nx[CNT_W'(ADDR_W - 1) - bit_nx];
        end
    end

    // SPI pins are registered from the next state so they change with the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            fetch_addr <= RESET_ADDR;
            spi_cs_n   <= 1'b1;
            spi_clk_en <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_nx;
            fetch_addr <= fetch_addr_nx;
            spi_cs_n   <= (state_nx == ST_IDLE);
            spi_clk_en <= (state_nx == ST_CMD) || (state_nx == ST_ADDR) || (state_nx == ST_DATA);
            spi_mosi   <= mosi_nx;
        end
    end

    // Core-facing instruction, pass counters and program counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            counter     <= '0;
            cycle       <= '0;
            pc          <= RESET_ADDR;
        end else begin
            if (instr_valid) begin
                counter <= counter + CNT_W'(1);
            end
            if (redirect_c) begin
                instr_valid <= 1'b0;
                pc          <= branch_addr & WORD_ALIGN_MASK;
            end else if (hold_c) begin
                cycle <= cycle + CYC_W'(1);
            end else if (drain_c) begin
                instr       <= buf_word_c;
                instr_valid <= 1'b1;
                counter     <= '0;
                cycle       <= '0;
                if (instr_valid) begin
                    pc <= pc + ADDR_W'(4);
                end
            end else if (wrap_c) begin
                instr_valid <= 1'b0;
                pc          <= pc + ADDR_W'(4);
            end
        end
    end

endmodule

// File: tb/tb_nanov_fetch.sv
// Self-checking bench for nanov_fetch: SPI flash model plus a pass-level model of
// the instruction stream (66-edge start latency, 32-clock passes, branch/next_cycle).
module tb_nanov_fetch;

    localparam logic [23:0] TB_RESET_ADDR = 24'h000000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_clk_en;
    logic        branch = 1'b0;
    logic [23:0] branch_addr = 24'h0;
    logic        next_cycle = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [4:0]  counter;
    logic [2:0]  cycle;
    logic [23:0] pc;

    always #5 clk = ~clk;

    nanov_fetch #(.RESET_ADDR(TB_RESET_ADDR)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .spi_miso    (spi_miso),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_clk_en  (spi_clk_en),
        .branch      (branch),
        .branch_addr (branch_addr),
        .next_cycle  (next_cycle),
        .instr       (instr),
        .instr_valid (instr_valid),
        .counter     (counter),
        .cycle       (cycle),
        .pc          (pc)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flash contents: explicit overrides, otherwise a salted address hash.
    bit [7:0]  ovr [int];
    logic [7:0] salt = 8'h00;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (ovr.exists(int'(a))) return ovr[int'(a)];
        return a[7:0] ^ a[15:8] ^ (a[23:16] + salt) ^ 8'hA5;
    endfunction

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
    endfunction

    // SPI mode 0 flash: samples mosi on its rising edge (clk falling), shifts data out after the header.
    int          fl_n = 0;
    int          fl_d = 0;
    logic [31:0] fl_hdr = 32'h0;
    logic [7:0]  fl_byte = 8'h0;
    logic [23:0] exp_txn_addr = 24'h0;

    always @(negedge clk) begin
        if (spi_cs_n) begin
            fl_n = 0;
        end else if (spi_clk_en) begin
            if (fl_n < 32) begin
                fl_hdr = {fl_hdr[30:0], spi_mosi};
                if (fl_n == 31) begin
                    check_eq("spi_cmd", 32'(fl_hdr[31:24]), 32'h03);
                    check_eq("spi_addr", 32'(fl_hdr[23:0]), 32'(exp_txn_addr));
                end
            end else begin
                fl_d     = fl_n - 32;
                fl_byte  = flash_byte(fl_hdr[23:0] + 24'(fl_d / 8));
                spi_miso = fl_byte[7 - (fl_d % 8)];
            end
            fl_n++;
        end
    end

    // Pass-level reference model.
    bit          m_valid = 1'b0;
    int          m_wait = 66;
    logic [4:0]  m_counter = 5'd0;
    logic [2:0]  m_cycle = 3'd0;
    logic [23:0] m_pc = 24'h0;
    logic [31:0] m_instr = 32'h0;

    task automatic model_edge(input logic br, input logic nc, input logic [23:0] ba);
        if (!m_valid) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid   = 1'b1;
                m_counter = 5'd0;
                m_cycle   = 3'd0;
                m_instr   = flash_word(m_pc);
            end
        end else if (m_counter == 5'd31) begin
            m_counter = 5'd0;
            if (br) begin
                m_valid      = 1'b0;
                m_wait       = 66;
                m_pc         = ba & 24'hFFFFFC;
                exp_txn_addr = m_pc;
            end else if (nc) begin
                m_cycle = m_cycle + 3'd1;
            end else begin
                m_pc    = m_pc + 24'd4;
                m_instr = flash_word(m_pc);
                m_cycle = 3'd0;
            end
        end else begin
            m_counter = m_counter + 5'd1;
        end
    endtask

    task automatic compare_all();
        check_eq("instr_valid", 32'(instr_valid), 32'(m_valid));
        check_eq("counter", 32'(counter), 32'(m_counter));
        check_eq("pc", 32'(pc), 32'(m_pc));
        check_eq("spi_cs_n", 32'(spi_cs_n), 32'(!m_valid && m_wait == 66));
        if (m_valid) begin
            check_eq("instr", instr, m_instr);
            check_eq("cycle", 32'(cycle), 32'(m_cycle));
            check_eq("spi_clk_en_run", 32'(spi_clk_en), 32'(m_cycle == 3'd0));
        end else begin
            check_eq("spi_clk_en_start", 32'(spi_clk_en), 32'(m_wait >= 2 && m_wait <= 65));
        end
    endtask

    task automatic tick(input logic br, input logic nc, input logic [23:0] ba);
        branch      = br;
        next_cycle  = nc;
        branch_addr = ba;
        @(posedge clk);
        model_edge(br, nc, ba);
        #1 compare_all();
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        branch      = 1'b0;
        next_cycle  = 1'b0;
        branch_addr = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
        check_eq("rst_clk_en", 32'(spi_clk_en), 32'd0);
        check_eq("rst_instr", instr, 32'h00000013);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_counter", 32'(counter), 32'd0);
        check_eq("rst_cycle", 32'(cycle), 32'd0);
        check_eq("rst_pc", 32'(pc), 32'(TB_RESET_ADDR));
        @(negedge clk);
        rstn         = 1'b1;
        m_valid      = 1'b0;
        m_wait       = 66;
        m_counter    = 5'd0;
        m_cycle      = 3'd0;
        m_pc         = TB_RESET_ADDR;
        exp_txn_addr = TB_RESET_ADDR;
        #1 compare_all();
    endtask

    // Advance until the next edge is a pass end; bounded.
    task automatic align_wrap();
        for (int i = 0; i < 200; i++) begin
            if (m_valid && m_counter == 5'd31) break;
            tick(1'b0, 1'b0, 24'h0);
        end
        check_eq("align_counter", 32'(counter), 32'd31);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        salt = 8'($urandom);

        // Reset start-up with a single NOP word at address 0.
        ovr[0] = 8'h13; ovr[1] = 8'h00; ovr[2] = 8'h00; ovr[3] = 8'h00;
        do_reset();
        run_idle(66 + 64);

        // Two known words, reset pulse during ADDR, then an unstalled stream.
        ovr.delete();
        ovr[0] = 8'h93; ovr[1] = 8'h00; ovr[2] = 8'h10; ovr[3] = 8'h00;
        ovr[4] = 8'h13; ovr[5] = 8'h81; ovr[6] = 8'h20; ovr[7] = 8'h00;
        do_reset();
        run_idle(20);
        #2 rstn = 1'b0;
        #1;
        check_eq("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        check_eq("midrst_clk_en", 32'(spi_clk_en), 32'd0);
        do_reset();
        run_idle(66 + 8 * 32);

        // Three consecutive next_cycle passes, then resume.
        align_wrap();
        for (int i = 0; i < 96; i++) tick(1'b0, 1'b1, 24'h0);
        run_idle(96);

        // Branch to 0x100.
        align_wrap();
        tick(1'b1, 1'b0, 24'h000100);
        run_idle(66 + 64);

        // Branch near the top of the address space; stream wraps to 0.
        align_wrap();
        tick(1'b1, 1'b0, 24'hFFFFF7);
        run_idle(66 + 6 * 32);

        // Randomised branch / next_cycle traffic.
        for (int i = 0; i < 4000; i++) begin
            logic        br;
            logic        nc;
            logic [23:0] ba;
            br = ($urandom_range(0, 19) == 0);
            nc = ($urandom_range(0, 2) == 0);
            ba = ($urandom_range(0, 3) == 0) ? (24'hFFFFF0 | 24'($urandom_range(0, 15)))
                                             : 24'($urandom);
            tick(br, nc, ba);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
